ucsbece154a_run_checker: RTL and testbench

- Synthesizable run-and-check sequencer for self-checking simulation and FPGA bring-up of the single-cycle core.
- Holds the core in reset for a programmable number of cycles, then lets it run until a halt is detected (PC stuck) or a cycle budget expires.
- Then steps through a table of architectural-state checks one per cycle and reports done/pass, error count and first failing index.
- Sits beside ucsbece154a_top. An external probe mux maps check_idx_o onto register/RAM taps and an expected-value table.

---
 rtl/ucsbece154a_run_checker.sv | 162 ++++++++++++++++
 tb/tb_ucsbece154a_run_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_run_checker.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154a_run_checker
// Brief    : Holds the core in reset, runs it until halt or budget, then walks
//            a table of architectural-state checks and reports pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154a_run_checker #(
    parameter int DATA_W       = 32,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 20,
    parameter int HALT_DETECT  = 1,
    parameter int HALT_CYCLES  = 3,
    parameter int NUM_CHECKS   = 9,
    parameter int CNT_W        = 16,
    parameter int IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              dut_reset_o,
    input  logic [DATA_W-1:0] pc_i,
    output logic              check_valid_o,
    output logic [IDX_W-1:0]  check_idx_o,
    input  logic [DATA_W-1:0] check_actual_i,
    input  logic [DATA_W-1:0] check_expect_i,
    input  logic [DATA_W-1:0] check_mask_i,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic              timeout_o,
    output logic [IDX_W:0]    error_count_o,
    output logic [IDX_W-1:0]  first_fail_idx_o,
    output logic              done_o,
    output logic              pass_o
);

    localparam logic [1:0] S_RST_HOLD = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_CHECK    = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RUN_LIMIT = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] c_HALT_LIM  = CNT_W'(HALT_CYCLES);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'((NUM_CHECKS > 0) ? NUM_CHECKS - 1 : 0);
    localparam logic [IDX_W:0]   c_ERR_MAX   = '1;
    localparam bit               c_HALT_EN   = (HALT_DETECT != 0);
    localparam logic [1:0]       c_AFTER_RUN = (NUM_CHECKS == 0) ? S_DONE : S_CHECK;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_stable_cnt;
    logic [DATA_W-1:0] r_prev_pc;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W:0]    r_err;
    logic [IDX_W-1:0]  r_first_fail;
    logic              r_timeout;
    logic              r_dut_reset;
    logic              r_valid;
    logic              r_done;

    logic [CNT_W-1:0]  w_cycle_inc;
    logic              w_pc_same;
    logic [CNT_W-1:0]  w_stable_inc;
    logic              w_halt;
    logic              w_budget;
    logic              w_fail;
    logic              w_idx_last;
    logic              w_dut_reset_nxt;
    logic              w_valid_nxt;
    logic              w_done_nxt;

    // A zero cycle count marks the first RUN cycle, whose previous PC is stale.
    assign w_cycle_inc  = r_cycle_cnt + 1'b1;
    assign w_pc_same    = (r_cycle_cnt != '0) && (pc_i == r_prev_pc);
    assign w_stable_inc = w_pc_same ? (r_stable_cnt + 1'b1) : '0;
    assign w_halt       = c_HALT_EN && (w_stable_inc == c_HALT_LIM);
    assign w_budget     = (w_cycle_inc == c_RUN_LIMIT);
    assign w_fail       = |((check_actual_i ^ check_expect_i) & check_mask_i);
    assign w_idx_last   = (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RST_HOLD: if (r_hold_cnt == c_HOLD_LAST) w_next_state = S_RUN;
            S_RUN:      if (w_halt || w_budget)        w_next_state = c_AFTER_RUN;
            S_CHECK:    if (w_idx_last)                w_next_state = S_DONE;
            default:    w_next_state = r_state;
        endcase
    end

    // Status flags are decoded from the next state and registered.
    always_comb begin
        w_dut_reset_nxt = (w_next_state == S_RST_HOLD);
        w_valid_nxt     = (w_next_state == S_CHECK);
        w_done_nxt      = (w_next_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dut_reset <= 1'b1;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_dut_reset <= w_dut_reset_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt   <= '0;
            r_cycle_cnt  <= '0;
            r_stable_cnt <= '0;
            r_prev_pc    <= '0;
            r_idx        <= '0;
            r_err        <= '0;
            r_first_fail <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_RST_HOLD: r_hold_cnt <= r_hold_cnt + 1'b1;
                S_RUN: begin
                    r_cycle_cnt  <= w_cycle_inc;
                    r_prev_pc    <= pc_i;
                    r_stable_cnt <= w_stable_inc;
                    // A halt seen on the budget cycle is not a timeout.
                    if (c_HALT_EN && w_budget && !w_halt) r_timeout <= 1'b1;
                end
                S_CHECK: begin
                    if (w_fail) begin
                        if (r_err != c_ERR_MAX) r_err <= r_err + 1'b1;
                        if (r_err == '0)        r_first_fail <= r_idx;
                    end
                    if (!w_idx_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dut_reset_o      = r_dut_reset;
    assign check_valid_o    = r_valid;
    assign check_idx_o      = r_idx;
    assign cycle_count_o    = r_cycle_cnt;
    assign timeout_o        = r_timeout;
    assign error_count_o    = r_err;
    assign first_fail_idx_o = r_first_fail;
    assign done_o           = r_done;
    assign pass_o           = r_done & (r_err == '0) & ~r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_run_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154a_run_checker
// Brief    : Directed scoreboard bench for the run-and-check sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154a_run_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] act_tbl [16];
    logic [31:0] exp_tbl [16];
    logic [31:0] msk_tbl [16];

    int n_cmp  = 0;
    int n_fail = 0;
    string       tag_q [$];
    logic [63:0] val_q [$];

    always #5 clk = ~clk;

    // DUT A: no halt detect; DUT B: defaults; DUT C: empty check table.
    logic        a_dr, a_val, a_to, a_done, a_pass;
    logic [3:0]  a_idx, a_ff;
    logic [4:0]  a_err;
    logic [15:0] a_cc;
    logic        b_dr, b_val, b_to, b_done, b_pass;
    logic [3:0]  b_idx, b_ff;
    logic [4:0]  b_err;
    logic [15:0] b_cc;
    logic        c_dr, c_val, c_to, c_done, c_pass;
    logic [0:0]  c_idx, c_ff;
    logic [1:0]  c_err;
    logic [15:0] c_cc;

    ucsbece154a_run_checker #(.HALT_DETECT(0)) u_a (
        .clk(clk), .reset(reset), .dut_reset_o(a_dr), .pc_i(pc),
        .check_valid_o(a_val), .check_idx_o(a_idx),
        .check_actual_i(act_tbl[a_idx]), .check_expect_i(exp_tbl[a_idx]),
        .check_mask_i(msk_tbl[a_idx]), .cycle_count_o(a_cc), .timeout_o(a_to),
        .error_count_o(a_err), .first_fail_idx_o(a_ff), .done_o(a_done), .pass_o(a_pass)
    );

    ucsbece154a_run_checker u_b (
        .clk(clk), .reset(reset), .dut_reset_o(b_dr), .pc_i(pc),
        .check_valid_o(b_val), .check_idx_o(b_idx),
        .check_actual_i(act_tbl[b_idx]), .check_expect_i(exp_tbl[b_idx]),
        .check_mask_i(msk_tbl[b_idx]), .cycle_count_o(b_cc), .timeout_o(b_to),
        .error_count_o(b_err), .first_fail_idx_o(b_ff), .done_o(b_done), .pass_o(b_pass)
    );

    ucsbece154a_run_checker #(.NUM_CHECKS(0), .RUN_CYCLES(5), .HALT_DETECT(0)) u_c (
        .clk(clk), .reset(reset), .dut_reset_o(c_dr), .pc_i(pc),
        .check_valid_o(c_val), .check_idx_o(c_idx),
        .check_actual_i(act_tbl[0]), .check_expect_i(exp_tbl[0]),
        .check_mask_i(msk_tbl[0]), .cycle_count_o(c_cc), .timeout_o(c_to),
        .error_count_o(c_err), .first_fail_idx_o(c_ff), .done_o(c_done), .pass_o(c_pass)
    );

    logic        o_dr, o_val, o_to, o_done, o_pass;
    logic [3:0]  o_idx, o_ff;
    logic [4:0]  o_err;
    logic [15:0] o_cc;

    always_comb begin
        o_dr = a_dr; o_val = a_val; o_to = a_to; o_done = a_done; o_pass = a_pass;
        o_idx = a_idx; o_ff = a_ff; o_err = a_err; o_cc = a_cc;
        case (sel)
            2'd1: begin
                o_dr = b_dr; o_val = b_val; o_to = b_to; o_done = b_done; o_pass = b_pass;
                o_idx = b_idx; o_ff = b_ff; o_err = b_err; o_cc = b_cc;
            end
            2'd2: begin
                o_dr = c_dr; o_val = c_val; o_to = c_to; o_done = c_done; o_pass = c_pass;
                o_idx = {3'b000, c_idx}; o_ff = {3'b000, c_ff}; o_err = {3'b000, c_err}; o_cc = c_cc;
            end
            default: ;
        endcase
    end

    task automatic sb_push(input string t, input logic [63:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        n_cmp++;
        assert (val_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=0x%0h expected=<empty queue>", obs);
        end
        if (val_q.size() != 0) begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
            end
        end
    endtask

    task automatic sb_drain();
        n_cmp++;
        assert (val_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0 entries", val_q.size());
        end
        tag_q.delete();
        val_q.delete();
    endtask

    // kind 0: all match; 1: idx2 fails, idx5 differs only in masked-off bits;
    // 2: idx3 and idx7 fail, idx5 masked difference kept.
    task automatic set_tables(input int kind);
        for (int i = 0; i < 16; i++) begin
            exp_tbl[i] = 32'h0000_0100 + 32'(i) * 32'h0101_0101;
            act_tbl[i] = exp_tbl[i];
            msk_tbl[i] = 32'hFFFF_FFFF;
        end
        if (kind == 1) begin
            act_tbl[2] = 32'h6; exp_tbl[2] = 32'h7;
        end
        if (kind != 0) begin
            exp_tbl[5] = 32'h1234_5678; act_tbl[5] = 32'hABCD_5678; msk_tbl[5] = 32'h0000_FFFF;
        end
        if (kind == 2) begin
            act_tbl[3] = act_tbl[3] ^ 32'h1;
            act_tbl[7] = act_tbl[7] ^ 32'h8000_0000;
        end
    endtask

    // Called at a negedge; asserts reset across one posedge and checks reset state.
    task automatic pulse_reset();
        reset = 1'b1;
        sb_push("rst_dut_reset", 64'd1);
        sb_push("rst_check_valid", 64'd0);
        sb_push("rst_check_idx", 64'd0);
        sb_push("rst_cycle_count", 64'd0);
        sb_push("rst_timeout", 64'd0);
        sb_push("rst_error_count", 64'd0);
        sb_push("rst_first_fail", 64'd0);
        sb_push("rst_done", 64'd0);
        sb_push("rst_pass", 64'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_check(64'(o_dr));  sb_check(64'(o_val)); sb_check(64'(o_idx));
        sb_check(64'(o_cc));  sb_check(64'(o_to));  sb_check(64'(o_err));
        sb_check(64'(o_ff));  sb_check(64'(o_done)); sb_check(64'(o_pass));
        sb_drain();
    endtask

    // mode 0: PC never repeats; mode 1: PC steps 0,4,..,0x30 then holds.
    task automatic run_seq(input int mode, input int abort_n, input int e_run, input int e_chk,
                           input logic e_to, input int e_err, input int e_ff, input logic e_pass);
        int n_rst = 0;
        int n_run = 0;
        int n_chk = 0;
        bit got_done = 1'b0;
        bit aborted = 1'b0;
        for (int k = 0; k < e_chk; k++)
            if (abort_n == 0 || k < abort_n) sb_push("check_idx", 64'(k));
        if (abort_n == 0) begin
            sb_push("reset_hold_cycles", 64'd2);
            sb_push("run_cycles", 64'(e_run));
            sb_push("check_cycles", 64'(e_chk));
            sb_push("cycle_count", 64'(e_run));
            sb_push("timeout", 64'(e_to));
            sb_push("error_count", 64'(e_err));
            sb_push("first_fail_idx", 64'(e_ff));
            sb_push("pass", 64'(e_pass));
            sb_push("valid_at_done", 64'd0);
            sb_push("idx_at_done", 64'((e_chk > 0) ? e_chk - 1 : 0));
            sb_push("done_held", 64'd1);
            sb_push("cycle_count_frozen", 64'(e_run));
            sb_push("pass_held", 64'(e_pass));
        end
        for (int i = 0; i < 200 && !got_done && !aborted; i++) begin
            if (o_done) begin
                got_done = 1'b1;
            end else begin
                if (o_dr) begin
                    n_rst++;
                end else if (o_val) begin
                    sb_check(64'(o_idx));
                    n_chk++;
                    if (n_chk == abort_n) aborted = 1'b1;
                end else begin
                    if (mode == 1) pc = (n_run > 12) ? 32'h30 : 32'(n_run * 4);
                    else           pc = 32'h1000 + 32'(n_run * 4);
                    n_run++;
                end
                if (!aborted) @(negedge clk);
            end
        end
        if (abort_n == 0) begin
            n_cmp++;
            assert (got_done) else begin
                n_fail++;
                $error("FAIL done_reached observed=0 expected=1 within 200 cycles");
            end
            if (got_done) begin
                sb_check(64'(n_rst)); sb_check(64'(n_run)); sb_check(64'(n_chk));
                sb_check(64'(o_cc));  sb_check(64'(o_to));  sb_check(64'(o_err));
                sb_check(64'(o_ff));  sb_check(64'(o_pass)); sb_check(64'(o_val));
                sb_check(64'(o_idx));
                repeat (3) @(negedge clk);
                sb_check(64'(o_done)); sb_check(64'(o_cc)); sb_check(64'(o_pass));
            end
        end
        sb_drain();
    endtask

    initial begin
        set_tables(0);
        repeat (3) @(negedge clk);

        sel = 2'd0; set_tables(0); pulse_reset();
        run_seq(0, 0, 20, 9, 1'b0, 0, 0, 1'b1);

        sel = 2'd1; set_tables(0); pulse_reset();
        run_seq(1, 0, 16, 9, 1'b0, 0, 0, 1'b1);

        sel = 2'd1; pulse_reset();
        run_seq(0, 0, 20, 9, 1'b1, 0, 0, 1'b0);

        sel = 2'd0; set_tables(1); pulse_reset();
        run_seq(0, 0, 20, 9, 1'b0, 1, 2, 1'b0);

        set_tables(2); pulse_reset();
        run_seq(0, 0, 20, 9, 1'b0, 2, 3, 1'b0);

        set_tables(1); pulse_reset();
        run_seq(0, 5, 20, 9, 1'b0, 1, 2, 1'b0);
        pulse_reset();
        run_seq(0, 0, 20, 9, 1'b0, 1, 2, 1'b0);

        sel = 2'd2; set_tables(0); pulse_reset();
        run_seq(0, 0, 5, 0, 1'b0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
